// File: rtl/modulus_seq_if.sv
// modulus_seq_if: operand/result handshake bundle for the sequential modulo/divide unit.
interface modulus_seq_if #(
  parameter int     WIDTH = 9,
  parameter longint MOD   = 3
);
  localparam int MW = $clog2(MOD);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [MW-1:0]    m;
  logic [WIDTH-1:0] q;
  modport master (output in_valid, y, out_ready, input in_ready, out_valid, m, q);
  modport slave  (input in_valid, y, out_ready, output in_ready, out_valid, m, q);
endinterface

// File: rtl/modulus_seq.sv
// modulus_seq: y mod MOD and y / MOD by MSB-first restoring division, one bit per clock.
module modulus_seq #(
  parameter int     WIDTH = 9,
  parameter longint MOD   = 3
) (
  input logic          clk,
  input logic          rst,
  modulus_seq_if.slave bus
);
  localparam int MW = $clog2(MOD);
  localparam int CW = $clog2(WIDTH);
  localparam logic [MW:0] MD = (MW+1)'(MOD);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state;
  logic [MW-1:0]    r, r_nx, m;
  logic [WIDTH-1:0] sr, qa, qa_nx, q;
  logic [CW-1:0]    cnt;
  logic [MW:0]      t;
  logic             ge;
  // r < MOD keeps {r, next bit} within MW+1 bits
  always_comb begin
    t = {r, sr[WIDTH-1]};
    ge = t >= MD;
    r_nx = ge ? MW'(t - MD) : t[MW-1:0];
    qa_nx = {qa[WIDTH-2:0], ge};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r <= '0;
      qa <= '0;
      sr <= '0;
      cnt <= '0;
      m <= '0;
      q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          sr <= bus.y;
          r <= '0;
          qa <= '0;
          cnt <= CW'(WIDTH - 1);
          state <= BUSY;
        end
        BUSY: begin
          r <= r_nx;
          qa <= qa_nx;
          sr <= sr << 1;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            m <= r_nx;
            q <= qa_nx;
            state <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.m = m;
  assign bus.q = q;
endmodule
